reg_file: RTL and testbench

//  Architectural register file for the single-cycle processor; sits directly downstream of the

---
 rtl/reg_file.sv | 76 +++++++
 tb/tb_reg_file.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Register file: R0..R14 in flops, R15 reads return the supplied PC+8, two combinational
// read ports and one synchronous write port. Optional write-through: REG_FILE_BYPASS_EN.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegW,
  input  logic                  RegSrc,
  input  logic [ADDR_WIDTH-1:0] RA1,
  input  logic [ADDR_WIDTH-1:0] Rm,
  input  logic [ADDR_WIDTH-1:0] Rd,
  input  logic [ADDR_WIDTH-1:0] WA3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic [DATA_WIDTH-1:0] R15,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [ADDR_WIDTH-1:0] RA2
);

  localparam int NUM_REGS = (1 << ADDR_WIDTH) - 1;
  localparam logic [ADDR_WIDTH-1:0] PC_IDX = {ADDR_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  wr_en;

  // The PC is owned by fetch, so writes aimed at its index are dropped here.
  assign wr_en = RegW && (WA3 != PC_IDX);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WA3] = WD3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign RA2 = RegSrc ? Rd : Rm;

  // PC override is checked first so it always beats the write-through path.
  always_comb begin
    if (RA1 == PC_IDX) begin
      RD1 = R15;
`ifdef REG_FILE_BYPASS_EN
    end else if (wr_en && !reset && (RA1 == WA3)) begin
      RD1 = WD3;
`endif
    end else begin
      RD1 = regs_q[RA1];
    end
  end

  always_comb begin
    if (RA2 == PC_IDX) begin
      RD2 = R15;
`ifdef REG_FILE_BYPASS_EN
    end else if (wr_en && !reset && (RA2 == WA3)) begin
      RD2 = WD3;
`endif
    end else begin
      RD2 = regs_q[RA2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, writes, PC handling, RegSrc select, reset priority,
// read-during-write and back-to-back writes.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        RegW;
  logic        RegSrc;
  logic [3:0]  RA1;
  logic [3:0]  Rm;
  logic [3:0]  Rd;
  logic [3:0]  WA3;
  logic [31:0] WD3;
  logic [31:0] R15;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [3:0]  RA2;

  int n_cmp = 0;
  int n_mis = 0;

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .RegW   (RegW),
    .RegSrc (RegSrc),
    .RA1    (RA1),
    .Rm     (Rm),
    .Rd     (Rd),
    .WA3    (WA3),
    .WD3    (WD3),
    .R15    (R15),
    .RD1    (RD1),
    .RD2    (RD2),
    .RA2    (RA2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
    RegW = 1'b1;
    WA3  = addr;
    WD3  = data;
    tick();
    RegW = 1'b0;
    WA3  = 4'd0;
    WD3  = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    RegSrc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      RA1 = 4'(i);
      Rm  = 4'(14 - i);
      #1;
      n_cmp++;
      if (RD1 !== 32'h0) begin
        n_mis++;
        $display("FAIL reset_rd1[%0d]: got %h want 00000000", i, RD1);
      end
      n_cmp++;
      if (RD2 !== 32'h0) begin
        n_mis++;
        $display("FAIL reset_rd2[%0d]: got %h want 00000000", 14 - i, RD2);
      end
    end
    RA1 = 4'd15;
    R15 = 32'h0000_0108;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0000_0108) begin
      n_mis++;
      $display("FAIL reset_pc_read: got %h want 00000108", RD1);
    end
  endtask

  task automatic test_write();
    do_write(4'd3, 32'hDEAD_BEEF);
    RA1 = 4'd3;
    #1;
    n_cmp++;
    if (RD1 !== 32'hDEAD_BEEF) begin
      n_mis++;
      $display("FAIL write_r3: got %h want deadbeef", RD1);
    end
    RA1 = 4'd2;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0) begin
      n_mis++;
      $display("FAIL write_neighbour_r2: got %h want 00000000", RD1);
    end
    RA1 = 4'd4;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0) begin
      n_mis++;
      $display("FAIL write_neighbour_r4: got %h want 00000000", RD1);
    end
  endtask

  task automatic test_pc_write();
    logic [31:0] exp_regs [15];
    for (int i = 0; i < 15; i++) exp_regs[i] = 32'h0;
    exp_regs[3] = 32'hDEAD_BEEF;
    RegW = 1'b1;
    WA3  = 4'd15;
    WD3  = 32'h1234_5678;
    RA1  = 4'd15;
    R15  = 32'h0000_0020;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0000_0020) begin
      n_mis++;
      $display("FAIL pc_write_same_cycle: got %h want 00000020", RD1);
    end
    tick();
    RegW = 1'b0;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0000_0020) begin
      n_mis++;
      $display("FAIL pc_write_next_cycle: got %h want 00000020", RD1);
    end
    // The dropped write must not land in any flop either.
    RegSrc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      Rm = 4'(i);
      #1;
      n_cmp++;
      if (RD2 !== exp_regs[i]) begin
        n_mis++;
        $display("FAIL pc_write_no_side_effect[%0d]: got %h want %h", i, RD2, exp_regs[i]);
      end
    end
  endtask

  task automatic test_regsrc();
    do_write(4'd5, 32'h0000_0005);
    do_write(4'd7, 32'h0000_0007);
    Rm     = 4'd5;
    Rd     = 4'd7;
    RegSrc = 1'b0;
    #1;
    n_cmp++;
    if (RA2 !== 4'd5) begin
      n_mis++;
      $display("FAIL regsrc0_ra2: got %0d want 5", RA2);
    end
    n_cmp++;
    if (RD2 !== 32'h0000_0005) begin
      n_mis++;
      $display("FAIL regsrc0_rd2: got %h want 00000005", RD2);
    end
    RegSrc = 1'b1;
    #1;
    n_cmp++;
    if (RA2 !== 4'd7) begin
      n_mis++;
      $display("FAIL regsrc1_ra2: got %0d want 7", RA2);
    end
    n_cmp++;
    if (RD2 !== 32'h0000_0007) begin
      n_mis++;
      $display("FAIL regsrc1_rd2: got %h want 00000007", RD2);
    end
    // Both ports on the same register return identical data.
    RA1 = 4'd7;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0000_0007 || RD2 !== 32'h0000_0007) begin
      n_mis++;
      $display("FAIL same_addr_both_ports: got %h/%h want 00000007/00000007", RD1, RD2);
    end
    RegSrc = 1'b0;
  endtask

  task automatic test_reset_dominates();
    do_write(4'd9, 32'hAAAA_0000);
    RA1 = 4'd9;
    #1;
    n_cmp++;
    if (RD1 !== 32'hAAAA_0000) begin
      n_mis++;
      $display("FAIL pre_reset_r9: got %h want aaaa0000", RD1);
    end
    reset = 1'b1;
    RegW  = 1'b1;
    WA3   = 4'd9;
    WD3   = 32'h1111_1111;
    tick();
    reset = 1'b0;
    RegW  = 1'b0;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_dominates_r9: got %h want 00000000", RD1);
    end
    RegSrc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      Rm = 4'(i);
      #1;
      n_cmp++;
      if (RD2 !== 32'h0) begin
        n_mis++;
        $display("FAIL midrun_reset_clear[%0d]: got %h want 00000000", i, RD2);
      end
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] exp_now;
    do_write(4'd4, 32'h0000_0001);
`ifdef REG_FILE_BYPASS_EN
    exp_now = 32'h0000_0002;
`else
    exp_now = 32'h0000_0001;
`endif
    RegW   = 1'b1;
    WA3    = 4'd4;
    WD3    = 32'h0000_0002;
    RA1    = 4'd4;
    Rm     = 4'd4;
    RegSrc = 1'b0;
    #1;
    n_cmp++;
    if (RD1 !== exp_now) begin
      n_mis++;
      $display("FAIL rdw_rd1_same_cycle: got %h want %h", RD1, exp_now);
    end
    n_cmp++;
    if (RD2 !== exp_now) begin
      n_mis++;
      $display("FAIL rdw_rd2_same_cycle: got %h want %h", RD2, exp_now);
    end
    tick();
    RegW = 1'b0;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0000_0002) begin
      n_mis++;
      $display("FAIL rdw_rd1_next_cycle: got %h want 00000002", RD1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back({4'(i), 4'hC, 8'(i * 17), 16'hA5F0 ^ 16'(i)});
    end
    RegW = 1'b1;
    for (int i = 0; i < 15; i++) begin
      WA3 = 4'(i);
      WD3 = exp_q[i];
      tick();
    end
    RegW   = 1'b0;
    RegSrc = 1'b1;
    for (int i = 0; i < 15; i++) begin
      RA1 = 4'(i);
      Rd  = 4'(14 - i);
      #1;
      n_cmp++;
      if (RD1 !== exp_q[i]) begin
        n_mis++;
        $display("FAIL b2b_rd1[%0d]: got %h want %h", i, RD1, exp_q[i]);
      end
      n_cmp++;
      if (RD2 !== exp_q[14 - i]) begin
        n_mis++;
        $display("FAIL b2b_rd2[%0d]: got %h want %h", 14 - i, RD2, exp_q[14 - i]);
      end
    end
    RA1 = 4'd15;
    Rd  = 4'd15;
    R15 = 32'hCAFE_0008;
    #1;
    n_cmp++;
    if (RD1 !== 32'hCAFE_0008 || RD2 !== 32'hCAFE_0008) begin
      n_mis++;
      $display("FAIL b2b_pc_both_ports: got %h/%h want cafe0008/cafe0008", RD1, RD2);
    end
  endtask

  initial begin
    reset  = 1'b1;
    RegW   = 1'b0;
    RegSrc = 1'b0;
    RA1    = 4'd0;
    Rm     = 4'd0;
    Rd     = 4'd0;
    WA3    = 4'd0;
    WD3    = 32'h0;
    R15    = 32'h0;
    test_reset();
    test_write();
    test_pc_write();
    test_regsrc();
    test_reset_dominates();
    test_read_during_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
